ahb_apb_bridge: RTL and testbench
=================================

# ahb_apb_bridge

AHB-Lite slave to APB master bridge: accepts one AHB word transfer at a time and converts it into an APB SETUP/ACCESS sequence. It stretches the AHB data phase with HREADYOUT until the APB peripheral completes. It sits on the AHB bus alongside the memory slave, selected by the address decoder, and drives the APB peripheral segment.

## Interface
- ADDR_W, 32, address width on both AHB and APB sides
- DATA_W, 32, data width on both sides (word transfers only)

- HCLK  in  1  clock; all logic on rising edge
- HRESET  in  1  reset, synchronous, active-high
- HSEL  in  1  bridge selected by decoder
- HADDR  in  ADDR_W  AHB address
- HTRANS  in  2  AHB transfer type; NONSEQ=2'b10, SEQ=2'b11 are valid
- HWRITE  in  1  1=write
- HSIZE  in  3  transfer size; only 3'b010 (word) supported
- HWDATA  in  DATA_W  write data, valid in the data phase
- HREADYOUT  out  1  0 stretches the data phase
- HRDATA  out  DATA_W  read data, registered
- HRESP  out  2  2'b00 OKAY, 2'b01 ERROR
- PADDR  out  ADDR_W  APB address
- PSEL  out  1  APB select
- PENABLE  out  1  APB access phase
- PWRITE  out  1  APB direction
- PWDATA  out  DATA_W  APB write data
- PRDATA  in  DATA_W  APB read data
- PREADY  in  1  APB completion / wait
- PSLVERR  in  1  APB error, sampled with PREADY

## Operation
- Accept: HSEL & HTRANS[1] & HREADYOUT, sampled in IDLE. IDLE/BUSY HTRANS are ignored and receive OKAY.
- On accept, register HADDR→PADDR, HWRITE→PWRITE, HSIZE.
- FSM states: IDLE, WDATA, SETUP, ACCESS, ERR1, ERR2.
- IDLE: HREADYOUT=1, HRESP=OKAY.
  - Accept with HSIZE≠3'b010 → ERR1; no APB access.
  - Accepted write → WDATA.
  - Accepted read → SETUP.
- WDATA: HREADYOUT=0; capture HWDATA→PWDATA; → SETUP.
- SETUP: PSEL=1, PENABLE=0, HREADYOUT=0; → ACCESS.
- ACCESS: PSEL=1, PENABLE=1, HREADYOUT=0.
  - PREADY=0: hold all APB outputs stable and stay in ACCESS.
  - PREADY=1, PSLVERR=0: on a read, capture PRDATA→HRDATA; → IDLE.
  - PREADY=1, PSLVERR=1: → ERR1. HRDATA is not updated.
- ERR1: HREADYOUT=0, HRESP=ERROR; → ERR2.
- ERR2: HREADYOUT=1, HRESP=ERROR; → IDLE.
  - Address phases presented in ERR2 are not accepted. The master drives HTRANS=IDLE after an error, per AHB-Lite.
- PSEL/PENABLE are 0 in all states other than SETUP/ACCESS.
- PADDR, PWRITE and PWDATA hold their last value outside a transfer.
- HRDATA holds the last successful read data.
- Only one transfer is outstanding. A back-to-back transfer is accepted in the IDLE cycle that completes the previous one; that IDLE cycle is its HREADYOUT=1 data-phase end.

## Timing
- Reset values, applied at the first HCLK edge with HRESET=1:
  - state=IDLE, HREADYOUT=1, HRESP=2'b00, HRDATA=0
  - PSEL=0, PENABLE=0, PWRITE=0, PADDR=0, PWDATA=0
- Reset mid-transfer: PSEL/PENABLE drop at that edge; no completion is reported on AHB.
- Read, PREADY=1 immediately:
  - accept at cycle 0; SETUP at 1, ACCESS at 2
  - cycle 3 is IDLE with HREADYOUT=1 and HRDATA valid
  - 2 wait states
- Write, PREADY=1 immediately:
  - accept at 0; WDATA at 1, SETUP at 2, ACCESS at 3
  - IDLE with HREADYOUT=1 at 4
  - 3 wait states
- Each PREADY=0 cycle in ACCESS adds one wait state.
- PSLVERR response: ACCESS completes → ERR1 (1 cycle) → ERR2 (1 cycle) → IDLE. This adds 2 cycles versus OKAY.
- Bad HSIZE: accept at 0; ERR1 at 1, ERR2 at 2, IDLE at 3. PSEL never asserts.

## Test plan
- Reset: assert HRESET 2 cycles during an ACCESS wait → next cycle PSEL=0, PENABLE=0, HREADYOUT=1, HRDATA=0.
- Read HADDR=0x0000_0010 with PRDATA=0xDEAD_BEEF and PREADY=1 → PSEL high cycles 1-2, PENABLE high cycle 2, HRDATA=0xDEAD_BEEF with HREADYOUT=1 at cycle 3, HRESP=00.
- Write HADDR=0x24, HWDATA=0x1234_5678, PREADY low 3 cycles → PADDR=0x24, PWRITE=1, PWDATA=0x1234_5678 stable through ACCESS. 6 wait states total, then OKAY.
- Read with PREADY=1, PSLVERR=1 → HRESP=01 for 2 cycles, HREADYOUT 0 then 1, HRDATA unchanged.
- HSIZE=3'b000 write → 2-cycle ERROR response, PSEL never asserted.
- Back-to-back NONSEQ read then write, and HTRANS=IDLE/BUSY with HSEL=1 → second transfer is accepted in the completing IDLE cycle. IDLE/BUSY cycles produce no APB activity and keep HREADYOUT=1.

Source files
------------

// File: rtl/ahb_apb_bridge_if.sv
// Bus bundle for the AHB-Lite slave / APB master bridge: AHB slave port, APB master port
// and a state debug tap. The bridge uses the slave modport; the bus side uses master.
interface ahb_apb_bridge_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [2:0]        HSIZE;
  logic [DATA_W-1:0] HWDATA;
  logic              HREADYOUT;
  logic [DATA_W-1:0] HRDATA;
  logic [1:0]        HRESP;
  logic [ADDR_W-1:0] PADDR;
  logic              PSEL;
  logic              PENABLE;
  logic              PWRITE;
  logic [DATA_W-1:0] PWDATA;
  logic [DATA_W-1:0] PRDATA;
  logic              PREADY;
  logic              PSLVERR;
  logic [2:0]        dbg_state;

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, PRDATA, PREADY, PSLVERR,
    output HREADYOUT, HRDATA, HRESP, PADDR, PSEL, PENABLE, PWRITE, PWDATA, dbg_state
  );

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, PRDATA, PREADY, PSLVERR,
    input  HREADYOUT, HRDATA, HRESP, PADDR, PSEL, PENABLE, PWRITE, PWDATA, dbg_state
  );
endinterface

// File: rtl/ahb_apb_bridge.sv
// AHB-Lite word-transfer slave that replays each accepted transfer as an APB
// SETUP/ACCESS sequence, stretching the AHB data phase until the peripheral completes.
module ahb_apb_bridge #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input logic             HCLK,
  input logic             HRESET,
  ahb_apb_bridge_if.slave bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_WDATA  = 3'd1,
    S_SETUP  = 3'd2,
    S_ACCESS = 3'd3,
    S_ERR1   = 3'd4,
    S_ERR2   = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] paddr_q, paddr_d;
  logic              pwrite_q, pwrite_d;
  logic [DATA_W-1:0] pwdata_q, pwdata_d;
  logic [DATA_W-1:0] hrdata_q, hrdata_d;

  logic       accept;
  logic       apb_done;
  logic       hreadyout;
  logic [1:0] hresp;
  logic       psel;
  logic       penable;

  // Handshake: an AHB address phase is taken only in IDLE (where HREADYOUT=1) when
  // HSEL is high and HTRANS is NONSEQ/SEQ; an APB access ends on PREADY=1 in ACCESS.
  assign accept   = (state_q == S_IDLE) && bus.HSEL &&
                    ((bus.HTRANS == 2'b10) || (bus.HTRANS == 2'b11));
  assign apb_done = (state_q == S_ACCESS) && bus.PREADY;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
      pwdata_q <= '0;
      hrdata_q <= '0;
    end else begin
      paddr_q  <= paddr_d;
      pwrite_q <= pwrite_d;
      pwdata_q <= pwdata_d;
      hrdata_q <= hrdata_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (bus.HSIZE != 3'b010) state_d = S_ERR1;
          else if (bus.HWRITE)     state_d = S_WDATA;
          else                     state_d = S_SETUP;
        end
      end
      S_WDATA:  state_d = S_SETUP;
      S_SETUP:  state_d = S_ACCESS;
      S_ACCESS: begin
        if (bus.PREADY) state_d = bus.PSLVERR ? S_ERR1 : S_IDLE;
      end
      S_ERR1:   state_d = S_ERR2;
      S_ERR2:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // APB address/data hold their last value between transfers.
  always_comb begin
    paddr_d  = paddr_q;
    pwrite_d = pwrite_q;
    pwdata_d = pwdata_q;
    hrdata_d = hrdata_q;
    if (accept) begin
      paddr_d  = bus.HADDR;
      pwrite_d = bus.HWRITE;
    end
    if (state_q == S_WDATA) begin
      pwdata_d = bus.HWDATA;
    end
    if (apb_done && !bus.PSLVERR && !pwrite_q) begin
      hrdata_d = bus.PRDATA;
    end
  end

  always_comb begin
    hreadyout = 1'b0;
    hresp     = 2'b00;
    psel      = 1'b0;
    penable   = 1'b0;
    case (state_q)
      S_IDLE:   hreadyout = 1'b1;
      S_SETUP:  psel      = 1'b1;
      S_ACCESS: begin
        psel    = 1'b1;
        penable = 1'b1;
      end
      S_ERR1:   hresp = 2'b01;
      S_ERR2: begin
        hreadyout = 1'b1;
        hresp     = 2'b01;
      end
      default:  hreadyout = 1'b0;
    endcase
  end

  assign bus.HREADYOUT = hreadyout;
  assign bus.HRESP     = hresp;
  assign bus.HRDATA    = hrdata_q;
  assign bus.PSEL      = psel;
  assign bus.PENABLE   = penable;
  assign bus.PADDR     = paddr_q;
  assign bus.PWRITE    = pwrite_q;
  assign bus.PWDATA    = pwdata_q;
  assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_ahb_apb_bridge.sv
// Self-checking bench for ahb_apb_bridge: AHB driver tasks, an APB responder/monitor,
// and a queue of expected {HRESP, wait states, HRDATA} per transfer.
module tb_ahb_apb_bridge;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int EW = 42;

  logic HCLK = 1'b0;
  logic HRESET;
  always #5 HCLK = ~HCLK;

  ahb_apb_bridge_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();
  ahb_apb_bridge #(.ADDR_W(AW), .DATA_W(DW)) dut (.HCLK(HCLK), .HRESET(HRESET), .bus(bus));

  int total = 0;
  int bad   = 0;

  logic [EW-1:0] exp_q[$];

  int          apb_waits = 0;
  bit          apb_err   = 1'b0;
  logic [31:0] apb_rdata = '0;
  logic [31:0] model_rdata = '0;
  logic [31:0] exp_paddr = '0;
  logic [31:0] exp_pwdata = '0;
  bit          exp_pwrite = 1'b0;
  logic [31:0] pending_wdata = '0;
  int          apb_cycles = 0;
  int          acc_cnt = 0;
  bit   [7:0]  tr_psel, tr_pen;
  logic [31:0] lat_paddr, lat_pwdata;
  logic        lat_pwrite;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge HCLK);
    #1;
  endtask

  task automatic bus_idle();
    bus.HSEL   = 1'b0;
    bus.HTRANS = 2'b00;
  endtask

  // Drives one address phase and pushes the expected outcome of that transfer.
  task automatic addr_phase(input logic [31:0] addr, input bit wr, input logic [2:0] size,
                            input logic [1:0] trans, input logic [31:0] wdata);
    logic [1:0] r;
    int         w;
    bus.HSEL   = 1'b1;
    bus.HADDR  = addr;
    bus.HWRITE = wr;
    bus.HSIZE  = size;
    bus.HTRANS = trans;
    pending_wdata = wdata;
    exp_paddr  = addr;
    exp_pwrite = wr;
    exp_pwdata = wdata;
    if (size != 3'b010) begin
      r = 2'b01;
      w = 1;
    end else begin
      w = (wr ? 3 : 2) + apb_waits;
      r = apb_err ? 2'b01 : 2'b00;
      if (apb_err) w++;
      else if (!wr) model_rdata = apb_rdata;
    end
    exp_q.push_back({r, 8'(w), model_rdata});
  endtask

  // Runs the data phase to its HREADYOUT=1 cycle and scores it; returns in that cycle.
  task automatic data_phase();
    logic [EW-1:0] e;
    int            waits;
    logic [1:0]    last_resp;
    step();
    bus_idle();
    bus.HWDATA = pending_wdata;
    waits = 0;
    last_resp = 2'b00;
    tr_psel = '0;
    tr_pen  = '0;
    while (bus.HREADYOUT !== 1'b1) begin
      if (waits < 8) begin
        tr_psel[waits] = bus.PSEL;
        tr_pen[waits]  = bus.PENABLE;
      end
      last_resp = bus.HRESP;
      waits++;
      if (waits > 60) begin
        check("timeout_hreadyout", {63'd0, bus.HREADYOUT}, 64'd1);
        break;
      end
      step();
    end
    e = exp_q.pop_front();
    check("hresp", {62'd0, bus.HRESP}, {62'd0, e[41:40]});
    check("waits", waits, {56'd0, e[39:32]});
    check("last_wait_resp", {62'd0, last_resp}, {62'd0, e[41:40]});
    check("hrdata", {32'd0, bus.HRDATA}, {32'd0, e[31:0]});
  endtask

  // APB peripheral: PREADY after apb_waits ACCESS cycles; also checks the APB signals.
  initial begin
    bus.PREADY  = 1'b0;
    bus.PSLVERR = 1'b0;
    bus.PRDATA  = '0;
    forever begin
      @(posedge HCLK);
      #2;
      if (bus.PSEL) apb_cycles++;
      if (bus.PSEL && !bus.PENABLE) begin
        check("setup_paddr", {32'd0, bus.PADDR}, {32'd0, exp_paddr});
        check("setup_pwrite", {63'd0, bus.PWRITE}, {63'd0, exp_pwrite});
        if (exp_pwrite) check("setup_pwdata", {32'd0, bus.PWDATA}, {32'd0, exp_pwdata});
        lat_paddr  = bus.PADDR;
        lat_pwrite = bus.PWRITE;
        lat_pwdata = bus.PWDATA;
      end else if (bus.PSEL && bus.PENABLE) begin
        check("access_paddr_stable", {32'd0, bus.PADDR}, {32'd0, lat_paddr});
        check("access_pwrite_stable", {63'd0, bus.PWRITE}, {63'd0, lat_pwrite});
        check("access_pwdata_stable", {32'd0, bus.PWDATA}, {32'd0, lat_pwdata});
      end
      if (bus.PSEL && bus.PENABLE) begin
        if (acc_cnt >= apb_waits) begin
          bus.PREADY  = 1'b1;
          bus.PSLVERR = apb_err;
          bus.PRDATA  = apb_rdata;
        end else begin
          bus.PREADY  = 1'b0;
          bus.PSLVERR = 1'b0;
          bus.PRDATA  = $urandom;
        end
        acc_cnt++;
      end else begin
        acc_cnt     = 0;
        bus.PREADY  = 1'b0;
        bus.PSLVERR = 1'b0;
        bus.PRDATA  = $urandom;
      end
    end
  end

  initial begin
    int snap;
    HRESET     = 1'b1;
    bus.HSEL   = 1'b0;
    bus.HADDR  = '0;
    bus.HTRANS = 2'b00;
    bus.HWRITE = 1'b0;
    bus.HSIZE  = 3'b010;
    bus.HWDATA = '0;
    step();
    step();
    check("rst_hreadyout", {63'd0, bus.HREADYOUT}, 64'd1);
    check("rst_hresp", {62'd0, bus.HRESP}, 64'd0);
    check("rst_hrdata", {32'd0, bus.HRDATA}, 64'd0);
    check("rst_psel", {63'd0, bus.PSEL}, 64'd0);
    check("rst_penable", {63'd0, bus.PENABLE}, 64'd0);
    check("rst_pwrite", {63'd0, bus.PWRITE}, 64'd0);
    check("rst_paddr", {32'd0, bus.PADDR}, 64'd0);
    check("rst_pwdata", {32'd0, bus.PWDATA}, 64'd0);
    check("rst_state", {61'd0, bus.dbg_state}, 64'd0);
    HRESET = 1'b0;
    step();

    // Reset while the peripheral is holding the bridge in ACCESS.
    apb_waits  = 20;
    apb_rdata  = 32'hCAFE_F00D;
    exp_paddr  = 32'h40;
    exp_pwrite = 1'b0;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h40; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
    step();
    bus_idle();
    step();
    step();
    check("pre_rst_penable", {63'd0, bus.PENABLE}, 64'd1);
    HRESET = 1'b1;
    step();
    check("midrst_psel", {63'd0, bus.PSEL}, 64'd0);
    check("midrst_penable", {63'd0, bus.PENABLE}, 64'd0);
    step();
    HRESET = 1'b0;
    check("midrst_hreadyout", {63'd0, bus.HREADYOUT}, 64'd1);
    check("midrst_hrdata", {32'd0, bus.HRDATA}, 64'd0);
    step();
    check("post_rst_psel", {63'd0, bus.PSEL}, 64'd0);
    model_rdata = '0;

    // Zero-wait read.
    apb_waits = 0; apb_err = 1'b0; apb_rdata = 32'hDEAD_BEEF;
    addr_phase(32'h10, 1'b0, 3'b010, 2'b10, 32'h0);
    data_phase();
    check("read_psel_trace", {62'd0, tr_psel[1:0]}, 64'b11);
    check("read_penable_trace", {62'd0, tr_pen[1:0]}, 64'b10);

    // Write with 3 PREADY-low cycles.
    apb_waits = 3;
    addr_phase(32'h24, 1'b1, 3'b010, 2'b10, 32'h1234_5678);
    data_phase();
    check("write_pwdata", {32'd0, bus.PWDATA}, 64'h1234_5678);
    check("write_pwrite", {63'd0, bus.PWRITE}, 64'd1);

    // Read answered with PSLVERR.
    apb_waits = 0; apb_err = 1'b1; apb_rdata = 32'h5555_AAAA;
    addr_phase(32'h30, 1'b0, 3'b010, 2'b10, 32'h0);
    data_phase();
    step();
    apb_err = 1'b0;

    // Unsupported HSIZE; an address phase offered in ERR2 must be ignored.
    snap = apb_cycles;
    addr_phase(32'h50, 1'b1, 3'b000, 2'b10, 32'hAAAA_0000);
    data_phase();
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HADDR = 32'h60; bus.HWRITE = 1'b0; bus.HSIZE = 3'b010;
    step();
    bus_idle();
    check("err2_no_accept_state", {61'd0, bus.dbg_state}, 64'd0);
    check("err2_no_accept_hready", {63'd0, bus.HREADYOUT}, 64'd1);
    step();
    check("err2_no_accept_psel", {63'd0, bus.PSEL}, 64'd0);
    check("badsize_no_apb", apb_cycles, snap);

    // Back-to-back read then write, then IDLE/BUSY, then SEQ read.
    apb_waits = 1; apb_rdata = 32'h0BAD_F00D;
    addr_phase(32'h100, 1'b0, 3'b010, 2'b10, 32'h0);
    data_phase();
    apb_waits = 0;
    addr_phase(32'h104, 1'b1, 3'b010, 2'b10, 32'h0000_0077);
    data_phase();
    snap = apb_cycles;
    bus.HSEL = 1'b1; bus.HTRANS = 2'b00;
    step();
    check("idle_hready", {63'd0, bus.HREADYOUT}, 64'd1);
    bus.HTRANS = 2'b01;
    step();
    check("busy_hready", {63'd0, bus.HREADYOUT}, 64'd1);
    check("busy_psel", {63'd0, bus.PSEL}, 64'd0);
    apb_rdata = 32'h1357_9BDF;
    addr_phase(32'h108, 1'b0, 3'b010, 2'b11, 32'h0);
    check("idle_busy_no_apb", apb_cycles, snap);
    data_phase();

    // Random transfers.
    for (int i = 0; i < 10; i++) begin
      apb_waits = $urandom_range(0, 3);
      apb_err   = ($urandom_range(0, 3) == 0);
      apb_rdata = $urandom;
      addr_phase({$urandom_range(0, 255), 2'b00}, 1'($urandom_range(0, 1)),
                 3'b010, 2'b10, $urandom);
      data_phase();
      if (apb_err) begin
        step();
      end
    end
    apb_err = 1'b0;
    step();

    check("queue_empty", exp_q.size(), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
